// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants and types for the 16x65 RAM-backed FIFO controller.
//   FIFO_DEPTH : RAM entries
//   FIFO_WIDTH : payload bits
//   PTR_W      : RAM address width
//   CNT_W      : occupancy counter width (0..17 must fit)
package nv_ram_fifo_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 65;
  localparam int PTR_W      = 4;
  localparam int CNT_W      = 5;

  typedef logic [FIFO_WIDTH-1:0] payload_t;
  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam cnt_t RAM_FULL_CNT = cnt_t'(FIFO_DEPTH);

  // Up/down counter step; simultaneous inc and dec cancel out.
  function automatic cnt_t cnt_step(input cnt_t c, input logic inc, input logic dec);
    return c + cnt_t'(inc) - cnt_t'(dec);
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_16x65.sv
// 16x65 single-port-read / single-port-write RAM model with a registered
// read address (ra_d) and a registered output (dout_r).
//   clk           : clock
//   pwrbus_ram_pd : power-control bus (no function in this model)
//   re, ra        : read-address capture enable and address
//   we, wa, di    : write enable, address, data
//   ore           : output-register enable; dout_r <= mem[ra_d]
//   dout          : registered read data
module nv_ram_rwsp_16x65
  import nv_ram_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic [31:0]           pwrbus_ram_pd,
  input  logic                  re,
  input  logic [PTR_W-1:0]      ra,
  input  logic                  we,
  input  logic [PTR_W-1:0]      wa,
  input  logic [FIFO_WIDTH-1:0] di,
  input  logic                  ore,
  output logic [FIFO_WIDTH-1:0] dout
);

  payload_t mem [FIFO_DEPTH];
  ptr_t     ra_d;
  payload_t dout_r;

  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= di;
    end
    if (re) begin
      ra_d <= ra;
    end
    if (ore) begin
      dout_r <= mem[ra_d];
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/nv_ram_fifo_ctl_16x65.sv
// Valid/ready FIFO controller around a 16x65 registered-output RAM.
// The read side is a two-stage stall pipeline built from the RAM's own
// registers: S1 = read address captured (s1_vld), S2 = output register
// loaded (s2_vld, presented as rd_pvld). Capacity is 17 entries: 16 in
// the RAM plus one held in the output register.
//   clk, reset          : clock, synchronous active-high reset
//   wr_pvld/wr_prdy/wr_pd : write handshake and payload
//   rd_pvld/rd_prdy/rd_pd : read handshake and payload (rd_pd = RAM dout)
//   fifo_count          : entries held (0..17)
//   idle                : fifo_count == 0
//   pwrbus_ram_pd       : forwarded to the RAM
module nv_ram_fifo_ctl_16x65
  import nv_ram_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_pvld,
  output logic                  wr_prdy,
  input  logic [FIFO_WIDTH-1:0] wr_pd,
  output logic                  rd_pvld,
  input  logic                  rd_prdy,
  output logic [FIFO_WIDTH-1:0] rd_pd,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  idle,
  input  logic [31:0]           pwrbus_ram_pd
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t unread_cnt;     // written, not yet issued to S1
  cnt_t ram_cnt;        // written, not yet captured into the output register
  cnt_t next_ram_cnt;
  cnt_t next_unread_cnt;
  logic s1_vld;
  logic s2_vld;
  logic wr_prdy_q;
  logic we;
  logic re;
  logic ore;

  always_comb begin
    we  = wr_pvld & wr_prdy;
    // Advance S1 into S2 whenever S2 is empty or being consumed.
    ore = ~reset & s1_vld & (~s2_vld | rd_prdy);
    // Issue a new read address whenever S1 is empty or moving on.
    re  = ~reset & (unread_cnt != '0) & (~s1_vld | ore);
    next_ram_cnt    = cnt_step(ram_cnt, we, ore);
    next_unread_cnt = cnt_step(unread_cnt, we, re);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      unread_cnt <= '0;
      ram_cnt    <= '0;
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      // Preloaded so the port opens in the first cycle after reset;
      // the output is masked while reset is held.
      wr_prdy_q  <= 1'b1;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (re) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      unread_cnt <= next_unread_cnt;
      // A RAM slot frees only once its data reaches the output register,
      // so an entry sitting in S1 can never be overwritten.
      ram_cnt    <= next_ram_cnt;
      wr_prdy_q  <= (next_ram_cnt < RAM_FULL_CNT);
      if (re) begin
        s1_vld <= 1'b1;
      end else if (ore) begin
        s1_vld <= 1'b0;
      end
      if (ore) begin
        s2_vld <= 1'b1;
      end else if (rd_prdy) begin
        s2_vld <= 1'b0;
      end
    end
  end

  assign wr_prdy    = wr_prdy_q & ~reset;
  assign rd_pvld    = s2_vld & ~reset;
  assign fifo_count = reset ? '0 : ram_cnt + cnt_t'(s2_vld);
  assign idle       = (fifo_count == '0);

  nv_ram_rwsp_16x65 u_ram (
    .clk           (clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .re            (re),
    .ra            (rd_ptr),
    .we            (we),
    .wa            (wr_ptr),
    .di            (wr_pd),
    .ore           (ore),
    .dout          (rd_pd)
  );

endmodule

// File: tb/tb_nv_ram_fifo_ctl_16x65.sv
module tb_nv_ram_fifo_ctl_16x65;

  logic        clk;
  logic        reset;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [64:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [64:0] rd_pd;
  logic [4:0]  fifo_count;
  logic        idle;
  logic [31:0] pwrbus_ram_pd;

  int errors = 0;
  int checks = 0;
  logic [64:0] sb_q[$];
  logic        hold_pend;
  logic [64:0] held_pd;
  int          n_pop;
  int          n_wr;

  nv_ram_fifo_ctl_16x65 dut (
    .clk           (clk),
    .reset         (reset),
    .wr_pvld       (wr_pvld),
    .wr_prdy       (wr_prdy),
    .wr_pd         (wr_pd),
    .rd_pvld       (rd_pvld),
    .rd_prdy       (rd_prdy),
    .rd_pd         (rd_pd),
    .fifo_count    (fifo_count),
    .idle          (idle),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle and run the scoreboard for this cycle.
  task automatic sample();
    logic [64:0] exp;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_vld", 65'(rd_pvld), 65'd1);
      chk("hold_pd", rd_pd, held_pd);
    end
    if (rd_pvld && rd_prdy) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed output %0h expected no output", rd_pd);
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        chk("rd_data", rd_pd, exp);
        n_pop++;
      end
    end
    hold_pend = rd_pvld && !rd_prdy;
    held_pd   = rd_pd;
    if (wr_pvld && wr_prdy) begin
      sb_q.push_back(wr_pd);
      n_wr++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
      sample();
      adv();
    end
    chk(tag, 65'(sb_q.size()), 65'd0);
  endtask

  initial begin
    int acc;
    bit got;
    reset = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    pwrbus_ram_pd = 32'h0; hold_pend = 1'b0; held_pd = '0; n_pop = 0; n_wr = 0;

    // Reset state
    adv();
    sample();
    chk("rst_rd_pvld", 65'(rd_pvld), 65'd0);
    chk("rst_wr_prdy", 65'(wr_prdy), 65'd0);
    chk("rst_count", 65'(fifo_count), 65'd0);
    chk("rst_idle", 65'(idle), 65'd1);
    adv();
    sample();
    adv();
    reset = 1'b0;
    sample();
    chk("post_rst_wr_prdy", 65'(wr_prdy), 65'd1);
    chk("post_rst_idle", 65'(idle), 65'd1);
    adv();

    // Single write, 3-cycle latency
    wr_pvld = 1'b1; wr_pd = 65'h1_0000_0000_0000_0001; rd_prdy = 1'b1;
    sample();
    chk("t1_wr_prdy", 65'(wr_prdy), 65'd1);
    adv();
    wr_pvld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sample();
      chk($sformatf("t1_pvld_c%0d", c), 65'(rd_pvld), 65'(c == 3));
      if (c == 3) chk("t1_pd", rd_pd, 65'h1_0000_0000_0000_0001);
      adv();
    end
    sample();
    chk("t1_idle_c4", 65'(idle), 65'd1);
    adv();

    // Fill to 17 with reads stalled, then drain
    rd_prdy = 1'b0; wr_pvld = 1'b1; acc = 0;
    for (int i = 0; i < 40 && acc < 17; i++) begin
      wr_pd = 65'(acc);
      sample();
      if (wr_prdy) acc++;
      adv();
    end
    wr_pvld = 1'b0;
    chk("t2_accepts", 65'(acc), 65'd17);
    sample();
    chk("t2_full_prdy", 65'(wr_prdy), 65'd0);
    chk("t2_count", 65'(fifo_count), 65'd17);
    adv();
    rd_prdy = 1'b1;
    sample();
    chk("t2_prdy_at_ore", 65'(wr_prdy), 65'd0);
    adv();
    sample();
    chk("t2_prdy_after_ore", 65'(wr_prdy), 65'd1);
    adv();
    drain("t2_drain", 40);
    sample();
    chk("t2_idle", 65'(idle), 65'd1);
    adv();

    // Continuous streaming, 40 items across two wraps
    rd_prdy = 1'b1;
    for (int c = 0; c < 46; c++) begin
      wr_pvld = (c < 40);
      wr_pd   = 65'(c);
      sample();
      chk($sformatf("t3_pvld_c%0d", c), 65'(rd_pvld), 65'(c >= 3 && c < 43));
      adv();
    end
    chk("t3_empty", 65'(sb_q.size()), 65'd0);

    // Random consumer backpressure
    n_pop = 0; acc = 0;
    for (int i = 0; i < 3000 && (acc < 200 || sb_q.size() != 0); i++) begin
      wr_pvld = (acc < 200);
      wr_pd   = {1'($urandom_range(0, 1)), $urandom, $urandom};
      rd_prdy = 1'($urandom_range(0, 1));
      sample();
      if (wr_pvld && wr_prdy) acc++;
      adv();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    chk("t4_accepts", 65'(acc), 65'd200);
    chk("t4_pops", 65'(n_pop), 65'd200);
    chk("t4_empty", 65'(sb_q.size()), 65'd0);

    // Reset as flush with 9 entries held
    rd_prdy = 1'b0; wr_pvld = 1'b1; acc = 0;
    for (int i = 0; i < 30 && acc < 9; i++) begin
      wr_pd = 65'(500 + acc);
      sample();
      if (wr_prdy) acc++;
      adv();
    end
    wr_pvld = 1'b0;
    sample();
    chk("t5_count9", 65'(fifo_count), 65'd9);
    adv();
    reset = 1'b1; hold_pend = 1'b0; sb_q.delete(); n_wr = 0;
    sample();
    chk("t5_rst_count", 65'(fifo_count), 65'd0);
    chk("t5_rst_pvld", 65'(rd_pvld), 65'd0);
    adv();
    reset = 1'b0;
    sample();
    chk("t5_after_count", 65'(fifo_count), 65'd0);
    chk("t5_after_pvld", 65'(rd_pvld), 65'd0);
    adv();
    wr_pvld = 1'b1; wr_pd = 65'hAA; rd_prdy = 1'b1;
    sample();
    adv();
    wr_pvld = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      sample();
      if (rd_pvld) begin
        chk("t5_first_read", rd_pd, 65'hAA);
        got = 1'b1;
      end
      adv();
    end
    chk("t5_got", 65'(got), 65'd1);

    // Write held against a full FIFO
    rd_prdy = 1'b0; wr_pvld = 1'b1; acc = 0;
    for (int i = 0; i < 40 && acc < 17; i++) begin
      wr_pd = 65'(1000 + acc);
      sample();
      if (wr_prdy) acc++;
      adv();
    end
    chk("t6_accepts", 65'(acc), 65'd17);
    wr_pd = 65'h1_DEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t6_prdy", 65'(wr_prdy), 65'd0);
      chk("t6_we", 65'(dut.we), 65'd0);
      chk("t6_wr_ptr", 65'(dut.wr_ptr), 65'(n_wr % 16));
      adv();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    drain("t6_drain", 40);
    sample();
    chk("t6_idle", 65'(idle), 65'd1);
    adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
